// File: rtl/sprite_animator_if.sv
// ROM bus between the sprite animator and its external image/colour-map ROM chain.
// The animator drives the address; the ROM returns a colour word some fixed cycles later.
interface sprite_animator_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [ADDR_W-1:0] image_addr_out;
  logic [11:0]       rom_pixel_in;

  modport master (output image_addr_out, input rom_pixel_in);
  modport slave  (input image_addr_out, output rom_pixel_in);
endinterface

// File: rtl/sprite_animator.sv
// Full-screen sprite overlay: scaled indexed image at (x, y) with transparent key,
// frame-synchronous slide-in and blink animation, ROM-latency matched hit pipeline.
module sprite_animator #(
  parameter int unsigned WIDTH        = 275,
  parameter int unsigned HEIGHT       = 44,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned SCALE_LOG2   = 0,
  parameter int unsigned ROM_LATENCY  = 2,
  parameter logic [11:0] TRANSPARENT  = 12'h0F0,
  parameter int unsigned SLIDE_START  = 200,
  parameter int unsigned SLIDE_STEP   = 4,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                     pixel_clk_in,
  input  logic                     rst_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic                     vsync_in,
  input  logic [10:0]              x_in,
  input  logic [9:0]               y_in,
  input  logic                     start_in,
  input  logic                     stop_in,
  input  logic                     blink_in,
  sprite_animator_if.master        rom_if,
  output logic [11:0]              pixel_out,
  output logic                     pixel_valid_out,
  output logic                     busy_out
);

  localparam int unsigned CW      = 12;
  localparam int unsigned OFF_W   = 10;
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] W_SPAN = CW'(WIDTH << SCALE_LOG2);
  localparam logic [CW-1:0] H_SPAN = CW'(HEIGHT << SCALE_LOG2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLIDE,
    ST_SHOW
  } state_e;

  state_e               state_q, state_d;
  logic [OFF_W-1:0]     offset_q, offset_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 hidden_q, hidden_d;
  logic                 vsync_q;
  logic                 tick_c;
  logic                 busy_q, busy_d;

  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ROM_LATENCY:0] hit_q, hit_d;
  logic [11:0]          pixel_q, pixel_d;
  logic                 valid_q, valid_d;

  logic [CW-1:0]        hc_c, vc_c, xs_c, ye_c, dx_c, dy_c;
  logic                 drawn_c, hit_c;

  assign tick_c = vsync_in & ~vsync_q;

  // Animation FSM; offset and blink phase only move on a frame tick.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    blink_cnt_d = blink_cnt_q;
    hidden_d    = hidden_q;
    unique case (state_q)
      ST_IDLE: begin
        blink_cnt_d = '0;
        hidden_d    = 1'b0;
      end
      ST_SLIDE: begin
        blink_cnt_d = '0;
        hidden_d    = 1'b0;
        if (tick_c) begin
          if (offset_q <= OFF_W'(SLIDE_STEP)) begin
            offset_d = '0;
            state_d  = ST_SHOW;
          end else begin
            offset_d = offset_q - OFF_W'(SLIDE_STEP);
          end
        end
      end
      ST_SHOW: begin
        if (!blink_in) begin
          blink_cnt_d = '0;
          hidden_d    = 1'b0;
        end else if (tick_c) begin
          if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            hidden_d    = ~hidden_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Stop dominates a simultaneous start; start from any state restarts the slide.
    if (stop_in) begin
      state_d     = ST_IDLE;
      offset_d    = '0;
      blink_cnt_d = '0;
      hidden_d    = 1'b0;
    end else if (start_in) begin
      state_d     = ST_SLIDE;
      offset_d    = OFF_W'(SLIDE_START);
      blink_cnt_d = '0;
      hidden_d    = 1'b0;
    end
    busy_d = (state_d == ST_SLIDE);
  end

  // Hit test in 12-bit unsigned space so offscreen positions clip instead of wrapping.
  always_comb begin
    hc_c    = CW'(hcount_in);
    vc_c    = CW'(vcount_in);
    xs_c    = CW'(x_in);
    ye_c    = CW'(y_in) + CW'(offset_q);
    dx_c    = hc_c - xs_c;
    dy_c    = vc_c - ye_c;
    drawn_c = (state_q == ST_SLIDE) || ((state_q == ST_SHOW) && !hidden_q);
    hit_c   = (hc_c >= xs_c) && (dx_c < W_SPAN) &&
              (vc_c >= ye_c) && (dy_c < H_SPAN) && drawn_c;
    addr_d  = addr_q;
    if (hit_c) begin
      addr_d = ADDR_W'(dx_c >> SCALE_LOG2) +
               ADDR_W'(dy_c >> SCALE_LOG2) * ADDR_W'(WIDTH);
    end
  end

  // Hit travels alongside the ROM read so it meets the colour word that it addressed.
  always_comb begin
    hit_d    = '0;
    hit_d[0] = hit_c;
    for (int unsigned i = 1; i <= ROM_LATENCY; i++) begin
      hit_d[i] = hit_q[i-1];
    end
    valid_d = hit_q[ROM_LATENCY] && (rom_if.rom_pixel_in != TRANSPARENT);
    pixel_d = valid_d ? rom_if.rom_pixel_in : 12'h000;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      offset_q    <= '0;
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
      vsync_q     <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      hit_q       <= '0;
      pixel_q     <= 12'h000;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
      vsync_q     <= vsync_in;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      hit_q       <= hit_d;
      pixel_q     <= pixel_d;
      valid_q     <= valid_d;
    end
  end

  assign rom_if.image_addr_out = addr_q;
  assign pixel_out             = pixel_q;
  assign pixel_valid_out       = valid_q;
  assign busy_out              = busy_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: three instances (default, ROM latency 3, scale x2)
// share one control stimulus, each with its own latency-matched ROM model.
`timescale 1ns/1ps
module tb_sprite_animator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount = 11'd0;
  logic [9:0]  vcount = 10'd1000;
  logic        vsync = 1'b0;
  logic [10:0] x_pos = 11'd182;
  logic [9:0]  y_pos = 10'd34;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        blink = 1'b0;

  logic [11:0] pix_a, pix_b, pix_c;
  logic        val_a, val_b, val_c;
  logic        busy_a, busy_b, busy_c;

  int n_cmp = 0;
  int n_err = 0;

  logic        va [1:5];
  logic        vb [1:5];
  logic        vcs[1:5];
  logic [11:0] pa [1:5];
  logic [11:0] pb [1:5];
  logic [11:0] pc [1:5];
  logic [15:0] addr_a1, addr_c1;

  always #5 clk = ~clk;

  sprite_animator_if #(.ADDR_W(16)) bus_a ();
  sprite_animator_if #(.ADDR_W(16)) bus_b ();
  sprite_animator_if #(.ADDR_W(16)) bus_c ();

  sprite_animator u_a (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .vsync_in(vsync), .x_in(x_pos), .y_in(y_pos), .start_in(start), .stop_in(stop),
    .blink_in(blink), .rom_if(bus_a), .pixel_out(pix_a), .pixel_valid_out(val_a),
    .busy_out(busy_a));

  sprite_animator #(.ROM_LATENCY(3)) u_b (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .vsync_in(vsync), .x_in(x_pos), .y_in(y_pos), .start_in(start), .stop_in(stop),
    .blink_in(blink), .rom_if(bus_b), .pixel_out(pix_b), .pixel_valid_out(val_b),
    .busy_out(busy_b));

  sprite_animator #(.SCALE_LOG2(1)) u_c (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .vsync_in(vsync), .x_in(x_pos), .y_in(y_pos), .start_in(start), .stop_in(stop),
    .blink_in(blink), .rom_if(bus_c), .pixel_out(pix_c), .pixel_valid_out(val_c),
    .busy_out(busy_c));

  // ROM contents: two hand-placed key/near-key words, arithmetic pattern elsewhere.
  function automatic logic [11:0] rom_fn(input logic [15:0] a);
    if (a == 16'd100) return 12'h0F0;
    if (a == 16'd101) return 12'h0F1;
    return 12'(a * 16'd3 + 16'd257);
  endfunction

  logic [11:0] rom_a_q [0:1];
  logic [11:0] rom_b_q [0:2];
  logic [11:0] rom_c_q [0:1];
  always @(posedge clk) begin
    rom_a_q[0] <= rom_fn(bus_a.image_addr_out);
    rom_a_q[1] <= rom_a_q[0];
    rom_b_q[0] <= rom_fn(bus_b.image_addr_out);
    rom_b_q[1] <= rom_b_q[0];
    rom_b_q[2] <= rom_b_q[1];
    rom_c_q[0] <= rom_fn(bus_c.image_addr_out);
    rom_c_q[1] <= rom_c_q[0];
  end
  assign bus_a.rom_pixel_in = rom_a_q[1];
  assign bus_b.rom_pixel_in = rom_b_q[2];
  assign bus_c.rom_pixel_in = rom_c_q[1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 vsync = 1'b1;
      @(posedge clk); #1 vsync = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Present one pixel coordinate for one cycle, then record outputs 1..5 cycles later.
  task automatic probe(input logic [10:0] h, input logic [9:0] v);
    @(posedge clk); #1 hcount = h; vcount = v;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        hcount  = 11'd0;
        vcount  = 10'd1000;
        addr_a1 = bus_a.image_addr_out;
        addr_c1 = bus_c.image_addr_out;
      end
      va[k] = val_a; pa[k] = pix_a;
      vb[k] = val_b; pb[k] = pix_b;
      vcs[k] = val_c; pc[k] = pix_c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({val_a, val_b, val_c, busy_a, busy_b, busy_c} !== 6'b0 ||
        {pix_a, pix_b, pix_c} !== 36'h0 || bus_a.image_addr_out !== 16'd0) begin
      n_err++;
      $display("FAIL reset_outputs valid=%b%b%b busy=%b pix=%h addr=%0d want all zero",
               val_a, val_b, val_c, busy_a, pix_a, bus_a.image_addr_out);
    end
    rst = 1'b0;
    probe(11'd182, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b0 || pa[4] !== 12'h000) begin
      n_err++;
      $display("FAIL idle_not_drawn valid=%b pix=%h want 0/000", va[4], pa[4]);
    end
  endtask

  task automatic test_slide();
    pulse_start();
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_err++; $display("FAIL busy_after_start got=%b want=1", busy_a);
    end
    ticks(1);
    probe(11'd182, 10'd230);
    n_cmp++;
    if (va[4] !== 1'b1 || pa[4] !== rom_fn(16'd0)) begin
      n_err++; $display("FAIL slide_top_230 valid=%b pix=%h want 1/%h", va[4], pa[4], rom_fn(16'd0));
    end
    probe(11'd182, 10'd229);
    n_cmp++;
    if (va[4] !== 1'b0) begin
      n_err++; $display("FAIL slide_above_230 valid=%b want 0", va[4]);
    end
    ticks(10);
    probe(11'd182, 10'd190);
    n_cmp++;
    if (va[4] !== 1'b1) begin
      n_err++; $display("FAIL slide_top_190 valid=%b want 1", va[4]);
    end
    pulse_start();
    ticks(1);
    probe(11'd182, 10'd230);
    n_cmp++;
    if (va[4] !== 1'b1 || busy_a !== 1'b1) begin
      n_err++; $display("FAIL restart_top_230 valid=%b busy=%b want 1/1", va[4], busy_a);
    end
    ticks(48);
    probe(11'd182, 10'd37);
    n_cmp++;
    if (va[4] !== 1'b0 || busy_a !== 1'b1) begin
      n_err++; $display("FAIL tick49_row37 valid=%b busy=%b want 0/1", va[4], busy_a);
    end
    probe(11'd182, 10'd38);
    n_cmp++;
    if (va[4] !== 1'b1) begin
      n_err++; $display("FAIL tick49_top_38 valid=%b want 1", va[4]);
    end
    ticks(1);
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++; $display("FAIL busy_after_50_ticks got=%b want=0", busy_a);
    end
    ticks(10);
  endtask

  task automatic test_show_corners();
    probe(11'd456, 10'd77);
    n_cmp++;
    if (addr_a1 !== 16'd12099 || va[4] !== 1'b1 || pa[4] !== rom_fn(16'd12099)) begin
      n_err++; $display("FAIL corner_456_77 addr=%0d valid=%b pix=%h want 12099/1/%h",
                        addr_a1, va[4], pa[4], rom_fn(16'd12099));
    end
    probe(11'd182, 10'd34);
    n_cmp++;
    if (addr_a1 !== 16'd0 || va[4] !== 1'b1 || pa[4] !== rom_fn(16'd0)) begin
      n_err++; $display("FAIL origin_182_34 addr=%0d valid=%b pix=%h want 0/1/%h",
                        addr_a1, va[4], pa[4], rom_fn(16'd0));
    end
    n_cmp++;
    if (va[3] !== 1'b0 || va[5] !== 1'b0) begin
      n_err++; $display("FAIL latency2_window t+3=%b t+5=%b want 0/0", va[3], va[5]);
    end
    n_cmp++;
    if (vb[4] !== 1'b0 || vb[5] !== 1'b1 || pb[5] !== rom_fn(16'd0)) begin
      n_err++; $display("FAIL latency3_window t+4=%b t+5=%b pix=%h want 0/1/%h",
                        vb[4], vb[5], pb[5], rom_fn(16'd0));
    end
    probe(11'd457, 10'd77);
    n_cmp++;
    if (va[4] !== 1'b0 || pa[4] !== 12'h000) begin
      n_err++; $display("FAIL right_of_457 valid=%b pix=%h want 0/000", va[4], pa[4]);
    end
    probe(11'd181, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b0 || pa[4] !== 12'h000) begin
      n_err++; $display("FAIL left_of_181 valid=%b pix=%h want 0/000", va[4], pa[4]);
    end
  endtask

  task automatic test_transparency();
    probe(11'd282, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b0 || pa[4] !== 12'h000) begin
      n_err++; $display("FAIL key_0F0 valid=%b pix=%h want 0/000", va[4], pa[4]);
    end
    probe(11'd283, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b1 || pa[4] !== 12'h0F1) begin
      n_err++; $display("FAIL near_key_0F1 valid=%b pix=%h want 1/0f1", va[4], pa[4]);
    end
  endtask

  task automatic test_scale();
    probe(11'd182, 10'd34);
    n_cmp++;
    if (addr_c1 !== 16'd0 || vcs[4] !== 1'b1 || pc[4] !== rom_fn(16'd0)) begin
      n_err++; $display("FAIL x2_origin addr=%0d valid=%b want 0/1", addr_c1, vcs[4]);
    end
    probe(11'd731, 10'd34);
    n_cmp++;
    if (addr_c1 !== 16'd274 || vcs[4] !== 1'b1 || pc[4] !== rom_fn(16'd274)) begin
      n_err++; $display("FAIL x2_col731 addr=%0d valid=%b want 274/1", addr_c1, vcs[4]);
    end
    probe(11'd183, 10'd35);
    n_cmp++;
    if (addr_c1 !== 16'd0 || vcs[4] !== 1'b1) begin
      n_err++; $display("FAIL x2_183_35 addr=%0d valid=%b want 0/1", addr_c1, vcs[4]);
    end
    probe(11'd732, 10'd34);
    n_cmp++;
    if (vcs[4] !== 1'b0 || pc[4] !== 12'h000) begin
      n_err++; $display("FAIL x2_col732 valid=%b pix=%h want 0/000", vcs[4], pc[4]);
    end
    probe(11'd182, 10'd121);
    n_cmp++;
    if (addr_c1 !== 16'd11825 || vcs[4] !== 1'b1) begin
      n_err++; $display("FAIL x2_row121 addr=%0d valid=%b want 11825/1", addr_c1, vcs[4]);
    end
    probe(11'd182, 10'd122);
    n_cmp++;
    if (vcs[4] !== 1'b0) begin
      n_err++; $display("FAIL x2_row122 valid=%b want 0", vcs[4]);
    end
  endtask

  task automatic test_blink();
    @(posedge clk); #1 blink = 1'b1;
    ticks(29);
    probe(11'd182, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b1) begin
      n_err++; $display("FAIL blink_tick29 valid=%b want 1", va[4]);
    end
    ticks(1);
    probe(11'd182, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b0 || pa[4] !== 12'h000) begin
      n_err++; $display("FAIL blink_tick30 valid=%b pix=%h want 0/000", va[4], pa[4]);
    end
    ticks(29);
    probe(11'd182, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b0) begin
      n_err++; $display("FAIL blink_tick59 valid=%b want 0", va[4]);
    end
    ticks(1);
    probe(11'd182, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b1) begin
      n_err++; $display("FAIL blink_tick60 valid=%b want 1", va[4]);
    end
    ticks(29);
    probe(11'd182, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b1) begin
      n_err++; $display("FAIL blink_tick89 valid=%b want 1", va[4]);
    end
    ticks(1);
    probe(11'd182, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b0) begin
      n_err++; $display("FAIL blink_tick90 valid=%b want 0", va[4]);
    end
    blink = 1'b0;
    probe(11'd182, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b1 || pa[4] !== rom_fn(16'd0)) begin
      n_err++; $display("FAIL blink_off_visible valid=%b pix=%h want 1/%h", va[4], pa[4], rom_fn(16'd0));
    end
  endtask

  task automatic test_stop_start_same_cycle();
    pulse_start();
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_err++; $display("FAIL busy_before_stop got=%b want=1", busy_a);
    end
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b0 || busy_c !== 1'b0) begin
      n_err++; $display("FAIL stop_wins_busy a=%b c=%b want 0/0", busy_a, busy_c);
    end
    probe(11'd182, 10'd234);
    n_cmp++;
    if (va[4] !== 1'b0 || pa[4] !== 12'h000 || vcs[4] !== 1'b0) begin
      n_err++; $display("FAIL stop_wins_row234 valid_a=%b pix=%h valid_c=%b want 0/000/0",
                        va[4], pa[4], vcs[4]);
    end
    probe(11'd182, 10'd34);
    n_cmp++;
    if (va[4] !== 1'b0 || pa[4] !== 12'h000 || vcs[4] !== 1'b0) begin
      n_err++; $display("FAIL stop_idle_row34 valid_a=%b pix=%h valid_c=%b want 0/000/0",
                        va[4], pa[4], vcs[4]);
    end
  endtask

  initial begin
    test_reset();
    test_slide();
    test_show_corners();
    test_transparency();
    test_scale();
    test_blink();
    test_stop_start_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
